// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - CSI-2 data types, FSM states, header ECC and CRC16 byte step
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_YUV422_8 = 6'h1E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC,
        ST_WAIT_EOT
    } state_t;

    // d[7:0] = DI, d[15:8] = WC low byte, d[23:16] = WC high byte
    function automatic logic [5:0] csi2_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_crc16_2byte.sv
// rtl/csi2_crc16_2byte.sv - registered CRC16 advanced by two bytes per enabled cycle
module csi2_crc16_2byte (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    output logic [15:0] crc
);
    import csi2_pkg::*;

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = 16'hFFFF;
        end else if (en) begin
            crc_d = crc16_step(crc16_step(crc_q, b0), b1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            crc_q <= 16'hFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/csi2_rx_depacketizer.sv
// rtl/csi2_rx_depacketizer.sv - 2-lane CSI-2 packet parser regenerating fv/lv/pixel pairs
module csi2_rx_depacketizer #(
    parameter logic [1:0] VC        = 2'd0,
    parameter logic [5:0] DT        = 6'h1E,
    parameter bit         CRC_CHECK = 1'b1,
    parameter bit         ECC_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hs_en,
    input  logic [7:0]  d0,
    input  logic [7:0]  d1,
    output logic        fv,
    output logic        lv,
    output logic        pix_valid,
    output logic [15:0] pixdata,
    output logic        ecc_err,
    output logic        crc_err,
    output logic        wc_err,
    output logic        trunc_err
);
    import csi2_pkg::*;

    state_t      state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  wcl_q, wcl_d;
    logic [14:0] cnt_q, cnt_d;
    logic        fwd_q, fwd_d;
    logic        fv_q, fv_d;
    logic        lv_q, lv_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pixdata_q, pixdata_d;
    logic        ecc_err_q, ecc_err_d;
    logic        crc_err_q, crc_err_d;
    logic        wc_err_q, wc_err_d;
    logic        trunc_err_q, trunc_err_d;

    logic [15:0] crc_val;
    logic [15:0] hdr_wc;
    logic        ecc_ok;

    assign hdr_wc = {d0, wcl_q};
    assign ecc_ok = (csi2_ecc({d0, wcl_q, di_q}) == d1[5:0]);

    // CRC restarts while idle so the first payload beat steps from the seed
    csi2_crc16_2byte u_crc (
        .clk   (clk),
        .rstn  (rstn),
        .clear (state_q == ST_IDLE),
        .en    ((state_q == ST_PAYLOAD) && hs_en),
        .b0    (d0),
        .b1    (d1),
        .crc   (crc_val)
    );

    always_comb begin
        state_d     = state_q;
        di_d        = di_q;
        wcl_d       = wcl_q;
        cnt_d       = cnt_q;
        fwd_d       = fwd_q;
        fv_d        = fv_q;
        lv_d        = 1'b0;
        pix_valid_d = 1'b0;
        pixdata_d   = pixdata_q;
        ecc_err_d   = 1'b0;
        crc_err_d   = 1'b0;
        wc_err_d    = 1'b0;
        trunc_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hs_en) begin
                    di_d    = d0;
                    wcl_d   = d1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (!hs_en) begin
                    trunc_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (ECC_CHECK && !ecc_ok) begin
                    ecc_err_d = 1'b1;
                    state_d   = ST_WAIT_EOT;
                end else if (di_q[5:0] < 6'h10) begin
                    if (di_q[7:6] == VC) begin
                        if (di_q[5:0] == DT_FS) begin
                            fv_d = 1'b1;
                        end else if (di_q[5:0] == DT_FE) begin
                            fv_d = 1'b0;
                        end
                    end
                    state_d = ST_WAIT_EOT;
                end else if (hdr_wc[0]) begin
                    wc_err_d = 1'b1;
                    state_d  = ST_WAIT_EOT;
                end else begin
                    fwd_d   = (di_q[5:0] == DT) && (di_q[7:6] == VC);
                    cnt_d   = hdr_wc[15:1];
                    state_d = (hdr_wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (!hs_en) begin
                    trunc_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    if (fwd_q) begin
                        pix_valid_d = 1'b1;
                        lv_d        = 1'b1;
                        pixdata_d   = {d1, d0};
                    end
                    cnt_d = cnt_q - 15'd1;
                    if (cnt_q == 15'd1) begin
                        state_d = ST_CRC;
                    end
                end
            end
            ST_CRC: begin
                if (!hs_en) begin
                    trunc_err_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    crc_err_d = CRC_CHECK && ({d1, d0} != crc_val);
                    state_d   = ST_WAIT_EOT;
                end
            end
            ST_WAIT_EOT: begin
                if (!hs_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            di_q        <= 8'h00;
            wcl_q       <= 8'h00;
            cnt_q       <= 15'd0;
            fwd_q       <= 1'b0;
            fv_q        <= 1'b0;
            lv_q        <= 1'b0;
            pix_valid_q <= 1'b0;
            pixdata_q   <= 16'h0000;
            ecc_err_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            wc_err_q    <= 1'b0;
            trunc_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            di_q        <= di_d;
            wcl_q       <= wcl_d;
            cnt_q       <= cnt_d;
            fwd_q       <= fwd_d;
            fv_q        <= fv_d;
            lv_q        <= lv_d;
            pix_valid_q <= pix_valid_d;
            pixdata_q   <= pixdata_d;
            ecc_err_q   <= ecc_err_d;
            crc_err_q   <= crc_err_d;
            wc_err_q    <= wc_err_d;
            trunc_err_q <= trunc_err_d;
        end
    end

    assign fv        = fv_q;
    assign lv        = lv_q;
    assign pix_valid = pix_valid_q;
    assign pixdata   = pixdata_q;
    assign ecc_err   = ecc_err_q;
    assign crc_err   = crc_err_q;
    assign wc_err    = wc_err_q;
    assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_csi2_rx_depacketizer.sv
// tb/tb_csi2_rx_depacketizer.sv - directed self-checking bench for csi2_rx_depacketizer
module tb_csi2_rx_depacketizer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hs_en;
    logic [7:0]  d0, d1;
    logic        fv, lv, pix_valid, ecc_err, crc_err, wc_err, trunc_err;
    logic [15:0] pixdata;
    logic        fv_nc, lv_nc, pix_valid_nc, ecc_err_nc, crc_err_nc, wc_err_nc, trunc_err_nc;
    logic [15:0] pixdata_nc;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int n_pv, n_lv, n_lv_rise, n_pix_bad, pix_idx;
    int n_ecc, n_crc, n_crc_nc, n_wc, n_trunc;
    int crc_err_cyc, crc_beat_cyc;
    logic lv_prev;
    logic [7:0] pay [0:511];

    always #5 clk = ~clk;

    csi2_rx_depacketizer dut (
        .clk(clk), .rstn(rstn), .hs_en(hs_en), .d0(d0), .d1(d1),
        .fv(fv), .lv(lv), .pix_valid(pix_valid), .pixdata(pixdata),
        .ecc_err(ecc_err), .crc_err(crc_err), .wc_err(wc_err), .trunc_err(trunc_err)
    );

    csi2_rx_depacketizer #(.CRC_CHECK(1'b0)) dut_nc (
        .clk(clk), .rstn(rstn), .hs_en(hs_en), .d0(d0), .d1(d1),
        .fv(fv_nc), .lv(lv_nc), .pix_valid(pix_valid_nc), .pixdata(pixdata_nc),
        .ecc_err(ecc_err_nc), .crc_err(crc_err_nc), .wc_err(wc_err_nc), .trunc_err(trunc_err_nc)
    );

    function automatic logic [5:0] ecc_model(input logic [23:0] h);
        ecc_model[0] = ^(h & 24'hF12CB7);
        ecc_model[1] = ^(h & 24'hF2555B);
        ecc_model[2] = ^(h & 24'h749A6D);
        ecc_model[3] = ^(h & 24'hB8E38E);
        ecc_model[4] = ^(h & 24'hDF03F0);
        ecc_model[5] = ^(h & 24'hEFFC00);
    endfunction

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ pay[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic fill_colorbar();
        logic [7:0] y_tab [0:7];
        y_tab = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};
        for (int i = 0; i < 480; i++) begin
            if (i % 2 == 1) pay[i] = y_tab[i / 60];
            else            pay[i] = 8'h80 + 8'((i / 60) * 16) + 8'(i % 4);
        end
    endtask

    task automatic clr_stats();
        n_pv = 0; n_lv = 0; n_lv_rise = 0; n_pix_bad = 0; pix_idx = 0; lv_prev = 1'b0;
        n_ecc = 0; n_crc = 0; n_crc_nc = 0; n_wc = 0; n_trunc = 0;
        crc_err_cyc = -1; crc_beat_cyc = -2;
    endtask

    task automatic step(input logic en, input logic [7:0] a, input logic [7:0] b);
        hs_en = en; d0 = a; d1 = b;
        @(posedge clk);
        #1;
        cyc++;
        if (pix_valid) begin
            if (pix_idx < 256 && pixdata !== {pay[2*pix_idx+1], pay[2*pix_idx]}) n_pix_bad++;
            pix_idx++;
            n_pv++;
        end
        if (lv) n_lv++;
        if (lv && !lv_prev) n_lv_rise++;
        lv_prev = lv;
        if (ecc_err) n_ecc++;
        if (crc_err) begin n_crc++; crc_err_cyc = cyc; end
        if (crc_err_nc) n_crc_nc++;
        if (wc_err) n_wc++;
        if (trunc_err) n_trunc++;
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [5:0] ecc_xor);
        logic [5:0] e;
        e = ecc_model({wc, di}) ^ ecc_xor;
        step(1'b1, di, wc[7:0]);
        step(1'b1, wc[15:8], {2'b00, e});
    endtask

    task automatic send_long(input logic [7:0] di, input logic [15:0] wc, input logic [5:0] ecc_xor,
                             input logic [15:0] crc, input int stop_after);
        send_hdr(di, wc, ecc_xor);
        for (int i = 0; i < int'(wc) / 2; i++) begin
            if (i == stop_after) begin
                step(1'b0, 8'h00, 8'h00);
                return;
            end
            step(1'b1, pay[2*i], pay[2*i+1]);
        end
        step(1'b1, crc[7:0], crc[15:8]);
        crc_beat_cyc = cyc;
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset();
        rstn = 1'b0; hs_en = 1'b0; d0 = 8'h00; d1 = 8'h00;
        repeat (3) step(1'b0, 8'h00, 8'h00);
        rstn = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        n_checks++;
        if ({fv, lv, pix_valid, pixdata, ecc_err, crc_err, wc_err, trunc_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got fv=%b lv=%b pv=%b pix=%h errs=%b%b%b%b expected all 0",
                     fv, lv, pix_valid, pixdata, ecc_err, crc_err, wc_err, trunc_err);
        end
    endtask

    task automatic test_frame_start_end();
        clr_stats();
        step(1'b1, 8'h00, 8'h00);
        n_checks++; if (fv !== 1'b0) begin n_fail++; $display("FAIL fs_early: got fv=%b expected 0", fv); end
        step(1'b1, 8'h00, 8'h00);
        n_checks++; if (fv !== 1'b1) begin n_fail++; $display("FAIL fs_set: got fv=%b expected 1", fv); end
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        n_checks++;
        if (n_ecc + n_crc + n_wc + n_trunc !== 0) begin
            n_fail++; $display("FAIL fs_no_err: got %0d error pulses expected 0", n_ecc + n_crc + n_wc + n_trunc);
        end
        send_hdr(8'h01, 16'h0000, 6'h00);
        n_checks++; if (fv !== 1'b0) begin n_fail++; $display("FAIL fe_clear: got fv=%b expected 0", fv); end
        step(1'b0, 8'h00, 8'h00);
        send_hdr(8'h01, 16'h0000, 6'h00);
        n_checks++; if (fv !== 1'b0) begin n_fail++; $display("FAIL fe_when_low: got fv=%b expected 0", fv); end
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_long_packet();
        fill_colorbar();
        clr_stats();
        send_long(8'h1E, 16'h01E0, 6'h00, crc_model(480), -1);
        n_checks++; if (n_pv !== 240) begin n_fail++; $display("FAIL long_pix_count: got %0d expected 240", n_pv); end
        n_checks++;
        if (n_lv !== 240 || n_lv_rise !== 1) begin
            n_fail++; $display("FAIL long_lv: got %0d cycles in %0d runs expected 240 in 1", n_lv, n_lv_rise);
        end
        n_checks++; if (n_pix_bad !== 0) begin n_fail++; $display("FAIL long_pixdata: got %0d bad pairs expected 0", n_pix_bad); end
        n_checks++;
        if (n_crc + n_crc_nc + n_ecc + n_wc + n_trunc !== 0) begin
            n_fail++; $display("FAIL long_no_err: got %0d error pulses expected 0", n_crc + n_crc_nc + n_ecc + n_wc + n_trunc);
        end
        n_checks++;
        if (pixdata !== {pay[479], pay[478]}) begin
            n_fail++; $display("FAIL pixdata_hold: got %h expected %h", pixdata, {pay[479], pay[478]});
        end
    endtask

    task automatic test_ecc_error();
        fill_colorbar();
        clr_stats();
        send_long(8'h1E, 16'h01E0, 6'h01, crc_model(480), -1);
        n_checks++; if (n_ecc !== 1) begin n_fail++; $display("FAIL ecc_pulse: got %0d expected 1", n_ecc); end
        n_checks++; if (n_lv !== 0 || n_pv !== 0) begin n_fail++; $display("FAIL ecc_no_lv: got lv %0d pv %0d expected 0 0", n_lv, n_pv); end
        clr_stats();
        send_long(8'h1E, 16'h01E0, 6'h00, crc_model(480), -1);
        n_checks++;
        if (n_pv !== 240 || n_crc !== 0) begin
            n_fail++; $display("FAIL ecc_recover: got pv %0d crc_err %0d expected 240 0", n_pv, n_crc);
        end
    endtask

    task automatic test_crc_error();
        logic [15:0] c;
        fill_colorbar();
        c = crc_model(480);
        pay[37] = pay[37] ^ 8'h5A;
        clr_stats();
        send_long(8'h1E, 16'h01E0, 6'h00, c, -1);
        n_checks++; if (n_pv !== 240) begin n_fail++; $display("FAIL crc_pix_count: got %0d expected 240", n_pv); end
        n_checks++; if (n_crc !== 1) begin n_fail++; $display("FAIL crc_pulse: got %0d expected 1", n_crc); end
        n_checks++;
        if (crc_err_cyc !== crc_beat_cyc) begin
            n_fail++; $display("FAIL crc_timing: got cycle %0d expected %0d", crc_err_cyc, crc_beat_cyc);
        end
        n_checks++; if (n_crc_nc !== 0) begin n_fail++; $display("FAIL crc_disabled: got %0d pulses expected 0", n_crc_nc); end
    endtask

    task automatic test_truncation();
        fill_colorbar();
        clr_stats();
        send_long(8'h1E, 16'h01E0, 6'h00, crc_model(480), 100);
        n_checks++; if (n_pv !== 100) begin n_fail++; $display("FAIL trunc_pix_count: got %0d expected 100", n_pv); end
        n_checks++;
        if (lv !== 1'b0 || pix_valid !== 1'b0 || trunc_err !== 1'b1) begin
            n_fail++; $display("FAIL trunc_outputs: got lv=%b pv=%b trunc=%b expected 0 0 1", lv, pix_valid, trunc_err);
        end
        step(1'b0, 8'h00, 8'h00);
        n_checks++; if (n_trunc !== 1) begin n_fail++; $display("FAIL trunc_single: got %0d expected 1", n_trunc); end
        send_hdr(8'h00, 16'h0000, 6'h00);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        n_checks++; if (fv !== 1'b1) begin n_fail++; $display("FAIL trunc_then_fs: got fv=%b expected 1", fv); end
    endtask

    task automatic test_filtering();
        fill_colorbar();
        clr_stats();
        send_long(8'h2A, 16'h01E0, 6'h00, crc_model(480), -1);
        send_long(8'h5E, 16'h01E0, 6'h00, crc_model(480), -1);
        n_checks++;
        if (n_lv !== 0 || n_pv !== 0) begin
            n_fail++; $display("FAIL filter_no_pix: got lv %0d pv %0d expected 0 0", n_lv, n_pv);
        end
        n_checks++;
        if (n_crc + n_ecc + n_wc + n_trunc !== 0) begin
            n_fail++; $display("FAIL filter_no_err: got %0d pulses expected 0", n_crc + n_ecc + n_wc + n_trunc);
        end
        clr_stats();
        send_long(8'h1E, 16'h01E1, 6'h00, crc_model(480), -1);
        n_checks++;
        if (n_wc !== 1 || n_pv !== 0) begin
            n_fail++; $display("FAIL odd_wc: got wc_err %0d pv %0d expected 1 0", n_wc, n_pv);
        end
    endtask

    task automatic test_reset_mid_packet();
        fill_colorbar();
        clr_stats();
        send_hdr(8'h1E, 16'h01E0, 6'h00);
        for (int i = 0; i < 50; i++) step(1'b1, pay[2*i], pay[2*i+1]);
        rstn = 1'b0;
        step(1'b1, pay[100], pay[101]);
        n_checks++;
        if ({fv, lv, pix_valid, pixdata} !== 19'd0) begin
            n_fail++; $display("FAIL reset_mid: got fv=%b lv=%b pv=%b pix=%h expected all 0", fv, lv, pix_valid, pixdata);
        end
        rstn = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        n_checks++;
        if (n_trunc + n_crc + n_ecc + n_wc !== 0) begin
            n_fail++; $display("FAIL reset_no_err: got %0d pulses expected 0", n_trunc + n_crc + n_ecc + n_wc);
        end
        clr_stats();
        send_long(8'h1E, 16'h01E0, 6'h00, crc_model(480), -1);
        n_checks++;
        if (n_pv !== 240 || n_pix_bad !== 0 || n_crc !== 0) begin
            n_fail++; $display("FAIL reset_recover: got pv %0d bad %0d crc %0d expected 240 0 0", n_pv, n_pix_bad, n_crc);
        end
    endtask

    initial begin
        test_reset();
        test_frame_start_end();
        test_long_packet();
        test_ecc_error();
        test_crc_error();
        test_truncation();
        test_filtering();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
